// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: serializes the core's instruction-fetch and data ports onto a
// single external memory port. One memory transaction is outstanding at a time;
// ties between the two ports are broken round-robin, and a data-side abort drops a
// store that memory has not yet accepted.
module core_mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_icache_req_valid,
  input  logic [XLEN-1:0]   io_icache_req_bits_addr,
  output logic              io_icache_resp_valid,
  output logic [XLEN-1:0]   io_icache_resp_bits_data,
  input  logic              io_dcache_abort,
  input  logic              io_dcache_req_valid,
  input  logic [XLEN-1:0]   io_dcache_req_bits_addr,
  input  logic [XLEN-1:0]   io_dcache_req_bits_data,
  input  logic [XLEN/8-1:0] io_dcache_req_bits_mask,
  output logic              io_dcache_resp_valid,
  output logic [XLEN-1:0]   io_dcache_resp_bits_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data
);

  localparam int MW = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Port identifiers used by grant_q / last_grant_q.
  localparam logic G_I = 1'b0;
  localparam logic G_D = 1'b1;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;

  logic            i_pend_q, i_pend_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic            d_pend_q, d_pend_d;
  logic [XLEN-1:0] d_addr_q, d_addr_d;
  logic [XLEN-1:0] d_data_q, d_data_d;
  logic [MW-1:0]   d_mask_q, d_mask_d;

  logic            i_resp_valid_q, i_resp_valid_d;
  logic [XLEN-1:0] i_resp_data_q, i_resp_data_d;
  logic            d_resp_valid_q, d_resp_valid_d;
  logic [XLEN-1:0] d_resp_data_q, d_resp_data_d;

  logic            d_is_store;
  logic            abort_eff;
  logic            d_avail;
  logic            i_cap;
  logic            d_cap;
  logic            i_done;
  logic            d_done;

  // A port can take a new request when idle, or in the cycle its response is shown.
  assign i_cap = io_icache_req_valid & (~i_pend_q | i_resp_valid_q);
  assign d_cap = io_dcache_req_valid & (~d_pend_q | d_resp_valid_q);

  // Abort only bites on a pending store that memory has not yet accepted; once the
  // data port is granted and in WAIT the store is committed.
  assign d_is_store = |d_mask_q;
  assign abort_eff  = io_dcache_abort & d_pend_q & d_is_store
                      & ~((state_q == S_WAIT) & (grant_q == G_D));
  // A store being aborted this cycle must not win arbitration.
  assign d_avail    = d_pend_q & ~abort_eff;

  // Arbitration FSM next state and memory request drive.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    i_done        = 1'b0;
    d_done        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    case (state_q)
      S_IDLE: begin
        if (i_pend_q && d_avail) begin
          grant_d = (last_grant_q == G_D) ? G_I : G_D;
          state_d = S_ISSUE;
        end else if (i_pend_q) begin
          grant_d = G_I;
          state_d = S_ISSUE;
        end else if (d_avail) begin
          grant_d = G_D;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (grant_q == G_D) begin
          mem_req_addr  = d_addr_q;
          mem_req_wdata = d_data_q;
          mem_req_wmask = d_mask_q;
        end else begin
          mem_req_addr  = i_addr_q;
        end
        if ((grant_q == G_D) && abort_eff) begin
          // Abort beats a simultaneous ready: no request goes out.
          state_d = S_IDLE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_d      = S_WAIT;
            last_grant_d = grant_q;
          end
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (grant_q == G_D) d_done = 1'b1;
          else                i_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-port request capture, pending tracking and response registers.
  always_comb begin
    i_addr_d       = i_cap ? io_icache_req_bits_addr : i_addr_q;
    d_addr_d       = d_cap ? io_dcache_req_bits_addr : d_addr_q;
    d_data_d       = d_cap ? io_dcache_req_bits_data : d_data_q;
    d_mask_d       = d_cap ? io_dcache_req_bits_mask : d_mask_q;
    i_pend_d       = i_cap ? 1'b1 : (i_done ? 1'b0 : i_pend_q);
    d_pend_d       = d_cap ? 1'b1 : ((d_done | abort_eff) ? 1'b0 : d_pend_q);
    i_resp_valid_d = i_done;
    i_resp_data_d  = i_done ? mem_resp_data : i_resp_data_q;
    d_resp_valid_d = d_done | abort_eff;
    d_resp_data_d  = d_resp_data_q;
    if (abort_eff)   d_resp_data_d = '0;
    else if (d_done) d_resp_data_d = d_is_store ? '0 : mem_resp_data;
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      grant_q        <= G_I;
      last_grant_q   <= G_D;
      i_pend_q       <= 1'b0;
      i_addr_q       <= '0;
      d_pend_q       <= 1'b0;
      d_addr_q       <= '0;
      d_data_q       <= '0;
      d_mask_q       <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      i_pend_q       <= i_pend_d;
      i_addr_q       <= i_addr_d;
      d_pend_q       <= d_pend_d;
      d_addr_q       <= d_addr_d;
      d_data_q       <= d_data_d;
      d_mask_q       <= d_mask_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
    end
  end

  assign io_icache_resp_valid     = i_resp_valid_q;
  assign io_icache_resp_bits_data = i_resp_data_q;
  assign io_dcache_resp_valid     = d_resp_valid_q;
  assign io_dcache_resp_bits_data = d_resp_data_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed steps from the test plan followed by a
// randomized phase checked against a transaction-level model of the two ports
// and a simple memory.
module tb_core_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        io_icache_req_valid;
  logic [31:0] io_icache_req_bits_addr;
  logic        io_icache_resp_valid;
  logic [31:0] io_icache_resp_bits_data;
  logic        io_dcache_abort;
  logic        io_dcache_req_valid;
  logic [31:0] io_dcache_req_bits_addr;
  logic [31:0] io_dcache_req_bits_data;
  logic [3:0]  io_dcache_req_bits_mask;
  logic        io_dcache_resp_valid;
  logic [31:0] io_dcache_resp_bits_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  core_mem_arbiter #(.XLEN(32)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_icache_req_valid      (io_icache_req_valid),
    .io_icache_req_bits_addr  (io_icache_req_bits_addr),
    .io_icache_resp_valid     (io_icache_resp_valid),
    .io_icache_resp_bits_data (io_icache_resp_bits_data),
    .io_dcache_abort          (io_dcache_abort),
    .io_dcache_req_valid      (io_dcache_req_valid),
    .io_dcache_req_bits_addr  (io_dcache_req_bits_addr),
    .io_dcache_req_bits_data  (io_dcache_req_bits_data),
    .io_dcache_req_bits_mask  (io_dcache_req_bits_mask),
    .io_dcache_resp_valid     (io_dcache_resp_valid),
    .io_dcache_resp_bits_data (io_dcache_resp_bits_data),
    .mem_req_valid            (mem_req_valid),
    .mem_req_ready            (mem_req_ready),
    .mem_req_addr             (mem_req_addr),
    .mem_req_wdata            (mem_req_wdata),
    .mem_req_wmask            (mem_req_wmask),
    .mem_resp_valid           (mem_resp_valid),
    .mem_resp_data            (mem_resp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Enter a new cycle (inputs are driven right after this).
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Mid-cycle sampling point.
  task automatic mid();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    io_icache_req_valid     = 1'b0;
    io_icache_req_bits_addr = '0;
    io_dcache_abort         = 1'b0;
    io_dcache_req_valid     = 1'b0;
    io_dcache_req_bits_addr = '0;
    io_dcache_req_bits_data = '0;
    io_dcache_req_bits_mask = '0;
    mem_req_ready           = 1'b1;
    mem_resp_valid          = 1'b0;
    mem_resp_data           = '0;
  endtask

  task automatic do_reset();
    next();
    reset = 1'b1;
    clear_inputs();
    mid();
    next();
    reset = 1'b0;
    mid();
  endtask

  // Drive a one-cycle memory response, then advance to the cycle the port pulses.
  task automatic respond(input logic [31:0] data);
    next();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mid();
    next();
    mem_resp_valid = 1'b0;
    mid();
  endtask

  // Single fetch with zero memory wait; checks the exact cycle-by-cycle latency.
  task automatic fetch_once(input string pfx, input logic [31:0] addr, input logic [31:0] data);
    next();
    io_icache_req_valid = 1'b1;
    io_icache_req_bits_addr = addr;
    mem_req_ready = 1'b1;
    mid();
    chk({pfx, " c0 valid"}, 32'(mem_req_valid), 0);
    next();
    io_icache_req_valid = 1'b0;
    mid();
    chk({pfx, " c1 valid"}, 32'(mem_req_valid), 0);
    next();
    mid();
    chk({pfx, " c2 valid"}, 32'(mem_req_valid), 1);
    chk({pfx, " c2 addr"}, mem_req_addr, addr);
    chk({pfx, " c2 wmask"}, 32'(mem_req_wmask), 0);
    next();
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mid();
    chk({pfx, " c3 resp_valid"}, 32'(io_icache_resp_valid), 0);
    next();
    mem_resp_valid = 1'b0;
    mid();
    chk({pfx, " c4 resp_valid"}, 32'(io_icache_resp_valid), 1);
    chk({pfx, " c4 resp_data"}, io_icache_resp_bits_data, data);
    next();
    mid();
    chk({pfx, " c5 resp_valid"}, 32'(io_icache_resp_valid), 0);
  endtask

  // Randomized-phase model state.
  logic [31:0] mem_model [logic [31:0]];
  int          i_pend, d_pend, busy, cd, port, must_next, stall;
  int          exp_i, exp_d, drove_i, drove_d, drove_resp, gen, p;
  logic [31:0] i_a, d_a, d_w, rdata, exp_i_data, exp_d_data, w;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  d_m, st_wmask;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  initial begin
    reset = 1'b1;
    clear_inputs();
    mid();
    // Reset state
    chk("rst mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst mem_req_addr", mem_req_addr, 0);
    chk("rst mem_req_wdata", mem_req_wdata, 0);
    chk("rst mem_req_wmask", 32'(mem_req_wmask), 0);
    chk("rst i_resp_valid", 32'(io_icache_resp_valid), 0);
    chk("rst d_resp_valid", 32'(io_dcache_resp_valid), 0);
    chk("rst i_resp_data", io_icache_resp_bits_data, 0);
    chk("rst d_resp_data", io_dcache_resp_bits_data, 0);
    next();
    reset = 1'b0;
    mid();

    // Test 1: single fetch, minimum latency
    fetch_once("t1", 32'h200, 32'h0000_0013);

    // Test 2: simultaneous fetch and load; fetch wins the first tie
    do_reset();
    next();
    io_icache_req_valid = 1'b1; io_icache_req_bits_addr = 32'h100;
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h400; io_dcache_req_bits_mask = 4'h0;
    mid();
    next();
    io_icache_req_valid = 1'b0; io_dcache_req_valid = 1'b0;
    mid();
    next();
    mid();
    chk("t2 first addr", mem_req_addr, 32'h100);
    chk("t2 first wmask", 32'(mem_req_wmask), 0);
    respond(32'hAAAA_0001);
    chk("t2 fetch resp_valid", 32'(io_icache_resp_valid), 1);
    chk("t2 fetch resp_data", io_icache_resp_bits_data, 32'hAAAA_0001);
    // A new fetch presented in the response cycle must be captured.
    io_icache_req_valid = 1'b1; io_icache_req_bits_addr = 32'h104;
    next();
    io_icache_req_valid = 1'b0;
    mid();
    chk("t2 second valid", 32'(mem_req_valid), 1);
    chk("t2 second addr", mem_req_addr, 32'h400);
    respond(32'hBBBB_0002);
    chk("t2 load resp_valid", 32'(io_dcache_resp_valid), 1);
    chk("t2 load resp_data", io_dcache_resp_bits_data, 32'hBBBB_0002);
    chk("t2 load no i pulse", 32'(io_icache_resp_valid), 0);
    next();
    mid();
    chk("t2 nobubble addr", mem_req_addr, 32'h104);
    respond(32'hCCCC_0003);
    chk("t2 fetch2 resp_data", io_icache_resp_bits_data, 32'hCCCC_0003);
    // Last served was the fetch port, so the next tie goes to the load.
    next();
    io_icache_req_valid = 1'b1; io_icache_req_bits_addr = 32'h108;
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h408;
    mid();
    next();
    io_icache_req_valid = 1'b0; io_dcache_req_valid = 1'b0;
    mid();
    next();
    mid();
    chk("t2 tie2 first addr", mem_req_addr, 32'h408);
    respond(32'hDDDD_0004);
    chk("t2 tie2 load data", io_dcache_resp_bits_data, 32'hDDDD_0004);
    next();
    mid();
    chk("t2 tie2 second addr", mem_req_addr, 32'h108);
    respond(32'hEEEE_0005);
    chk("t2 tie2 fetch data", io_icache_resp_bits_data, 32'hEEEE_0005);

    // Test 3: store with ready low for three ISSUE cycles
    next();
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h80;
    io_dcache_req_bits_data = 32'hDEAD_BEEF; io_dcache_req_bits_mask = 4'hF;
    mem_req_ready = 1'b0;
    mid();
    next();
    io_dcache_req_valid = 1'b0;
    mid();
    for (int k = 0; k < 4; k++) begin
      next();
      mem_req_ready = (k == 3);
      mid();
      chk("t3 valid", 32'(mem_req_valid), 1);
      chk("t3 addr", mem_req_addr, 32'h80);
      chk("t3 wdata", mem_req_wdata, 32'hDEAD_BEEF);
      chk("t3 wmask", 32'(mem_req_wmask), 32'hF);
    end
    next();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
    mid();
    chk("t3 wait valid", 32'(mem_req_valid), 0);
    chk("t3 early resp", 32'(io_dcache_resp_valid), 0);
    next();
    mem_resp_valid = 1'b0;
    mid();
    chk("t3 ack resp_valid", 32'(io_dcache_resp_valid), 1);
    chk("t3 ack resp_data", io_dcache_resp_bits_data, 0);

    // Test 4: store pending while a fetch is served, aborted for one cycle
    do_reset();
    next();
    io_icache_req_valid = 1'b1; io_icache_req_bits_addr = 32'h300;
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h80;
    io_dcache_req_bits_data = 32'hCAFE_F00D; io_dcache_req_bits_mask = 4'hF;
    mid();
    next();
    io_icache_req_valid = 1'b0; io_dcache_req_valid = 1'b0;
    mid();
    next();
    mid();
    chk("t4 fetch addr", mem_req_addr, 32'h300);
    chk("t4 fetch wmask", 32'(mem_req_wmask), 0);
    next();
    io_dcache_abort = 1'b1;
    mid();
    next();
    io_dcache_abort = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h33;
    mid();
    chk("t4 abort resp_valid", 32'(io_dcache_resp_valid), 1);
    chk("t4 abort resp_data", io_dcache_resp_bits_data, 0);
    next();
    mem_resp_valid = 1'b0;
    mid();
    chk("t4 fetch resp_data", io_icache_resp_bits_data, 32'h33);
    chk("t4 abort single pulse", 32'(io_dcache_resp_valid), 0);
    for (int k = 0; k < 4; k++) begin
      next();
      mid();
      chk("t4 no store request", 32'(mem_req_valid), 0);
    end

    // Test 4b: abort and ready together on a granted store
    next();
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h84;
    io_dcache_req_bits_mask = 4'h3;
    mid();
    next();
    io_dcache_req_valid = 1'b0;
    mid();
    next();
    io_dcache_abort = 1'b1; mem_req_ready = 1'b1;
    mid();
    chk("t4b abort beats ready", 32'(mem_req_valid), 0);
    next();
    io_dcache_abort = 1'b0;
    mid();
    chk("t4b resp_valid", 32'(io_dcache_resp_valid), 1);
    chk("t4b back to idle", 32'(mem_req_valid), 0);
    next();
    mid();
    chk("t4b still idle", 32'(mem_req_valid), 0);

    // Test 4c: abort is ignored for loads
    next();
    io_dcache_req_valid = 1'b1; io_dcache_req_bits_addr = 32'h88;
    io_dcache_req_bits_mask = 4'h0;
    mid();
    next();
    io_dcache_req_valid = 1'b0;
    mid();
    next();
    io_dcache_abort = 1'b1;
    mid();
    chk("t4c load not aborted", 32'(mem_req_valid), 1);
    chk("t4c load addr", mem_req_addr, 32'h88);
    next();
    io_dcache_abort = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    mid();
    next();
    mem_resp_valid = 1'b0;
    mid();
    chk("t4c load resp_valid", 32'(io_dcache_resp_valid), 1);
    chk("t4c load resp_data", io_dcache_resp_bits_data, 32'h77);

    // Test 5: reset while waiting for a response
    next();
    io_icache_req_valid = 1'b1; io_icache_req_bits_addr = 32'h500;
    mid();
    next();
    io_icache_req_valid = 1'b0;
    mid();
    next();
    mid();
    chk("t5 issue addr", mem_req_addr, 32'h500);
    next();
    reset = 1'b1;
    mid();
    chk("t5 rst i_resp_data", io_icache_resp_bits_data, 0);
    chk("t5 rst d_resp_data", io_dcache_resp_bits_data, 0);
    chk("t5 rst mem_req_valid", 32'(mem_req_valid), 0);
    next();
    reset = 1'b0;
    mid();
    next();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
    mid();
    next();
    mem_resp_valid = 1'b0;
    mid();
    chk("t5 late resp ignored", 32'(io_icache_resp_valid), 0);
    chk("t5 late resp data", io_icache_resp_bits_data, 0);
    fetch_once("t5 refetch", 32'h600, 32'h1234_5678);

    // Randomized phase
    do_reset();
    i_pend = 0; d_pend = 0; busy = 0; cd = 0; port = 0; must_next = -1; stall = 0;
    exp_i = 0; exp_d = 0; rdata = '0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      gen = (cyc < 1500);
      if (!gen && !i_pend && !d_pend && !busy && !exp_i && !exp_d) break;
      next();
      io_icache_req_valid = 1'b0;
      io_dcache_req_valid = 1'b0;
      drove_i = 0; drove_d = 0; drove_resp = 0;
      if (gen && !i_pend && $urandom_range(0, 2) == 0) begin
        i_a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        io_icache_req_valid = 1'b1;
        io_icache_req_bits_addr = i_a;
        drove_i = 1;
      end
      if (gen && !d_pend && $urandom_range(0, 2) == 0) begin
        d_a = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        d_w = $urandom;
        d_m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        io_dcache_req_valid = 1'b1;
        io_dcache_req_bits_addr = d_a;
        io_dcache_req_bits_data = d_w;
        io_dcache_req_bits_mask = d_m;
        drove_d = 1;
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_resp_valid = 1'b0;
      if (busy) begin
        if (cd == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rdata;
          drove_resp = 1;
        end else begin
          cd--;
        end
      end
      mid();
      chk("rnd i_resp_valid", 32'(io_icache_resp_valid), 32'(exp_i));
      if (exp_i) chk("rnd i_resp_data", io_icache_resp_bits_data, exp_i_data);
      chk("rnd d_resp_valid", 32'(io_dcache_resp_valid), 32'(exp_d));
      if (exp_d) chk("rnd d_resp_data", io_dcache_resp_bits_data, exp_d_data);
      exp_i = 0; exp_d = 0;
      if (stall) begin
        chk("rnd stall valid", 32'(mem_req_valid), 1);
        chk("rnd stall addr", mem_req_addr, st_addr);
        chk("rnd stall wdata", mem_req_wdata, st_wdata);
        chk("rnd stall wmask", 32'(mem_req_wmask), 32'(st_wmask));
        stall = 0;
      end
      if (busy) begin
        chk("rnd one outstanding", 32'(mem_req_valid), 0);
        if (drove_resp) begin
          busy = 0;
          if (port == 0) begin exp_i = 1; exp_i_data = rdata; i_pend = 0; end
          else           begin exp_d = 1; exp_d_data = rdata; d_pend = 0; end
        end
      end else if (mem_req_valid && !mem_req_ready) begin
        stall = 1;
        st_addr = mem_req_addr; st_wdata = mem_req_wdata; st_wmask = mem_req_wmask;
      end else if (mem_req_valid && mem_req_ready) begin
        p = (mem_req_addr < 32'h2000) ? 0 : 1;
        if (p == 0) begin
          chk("rnd i pending", 32'(i_pend), 1);
          chk("rnd i addr", mem_req_addr, i_a);
          chk("rnd i wmask", 32'(mem_req_wmask), 0);
          rdata = rd(i_a);
        end else begin
          chk("rnd d pending", 32'(d_pend), 1);
          chk("rnd d addr", mem_req_addr, d_a);
          chk("rnd d wmask", 32'(mem_req_wmask), 32'(d_m));
          if (d_m != 4'h0) begin
            chk("rnd d wdata", mem_req_wdata, d_w);
            w = rd(d_a);
            for (int b = 0; b < 4; b++) if (d_m[b]) w[8*b +: 8] = d_w[8*b +: 8];
            mem_model[d_a] = w;
            rdata = 32'h0;
          end else begin
            rdata = rd(d_a);
          end
        end
        if (must_next >= 0) chk("rnd round robin", 32'(p), 32'(must_next));
        must_next = ((p == 0) ? d_pend : i_pend) ? (1 - p) : -1;
        busy = 1;
        port = p;
        cd = $urandom_range(0, 3);
      end
      if (drove_i) i_pend = 1;
      if (drove_d) d_pend = 1;
    end
    chk("rnd drained", 32'(i_pend | d_pend | busy | exp_i | exp_d), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
